// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pkg
//  Purpose  : Shared constants and FSM state encoding for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] c_nop_instr   = 32'h0000_0013;
    localparam logic [31:0] c_ecall_instr = 32'h0000_0073;
    localparam int          c_pc_incr     = 4;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_instr_mem.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_instr_mem
//  Purpose  : Word-addressed instruction memory, async read / sync write.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage_instr_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Fetch stage: PC, loadable instruction memory, IF/ID register.
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          PC_SIZE   = 10,
    parameter logic [31:0] NOP_INSTR = c_nop_instr
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               imem_we,
    input  logic [PC_SIZE-3:0] imem_addr,
    input  logic [31:0]        imem_wdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_SIZE-1:0] branch_target,
    output logic [PC_SIZE-1:0] PC_out,
    output logic [31:0]        instruction,
    output logic               halted,
    output logic               loading
);

    fetch_state_t       r_state;
    logic [PC_SIZE-1:0] r_pc;
    logic [PC_SIZE-1:0] r_pc_out;
    logic [31:0]        r_instr;
    logic               r_halted;
    logic               r_loading;

    logic [31:0]        w_fetch_word;
    logic [PC_SIZE-1:0] w_pc_next;
    logic [PC_SIZE-1:0] w_redirect_pc;
    logic               w_mem_we;

    // The program can only be altered while the stage is in download mode.
    assign w_mem_we      = imem_we && (r_state == ST_LOAD);
    assign w_pc_next     = r_pc + PC_SIZE'(c_pc_incr);
    assign w_redirect_pc = {branch_target[PC_SIZE-1:2], 2'b00};

    if_stage_instr_mem #(
        .ADDR_W (PC_SIZE - 2),
        .DATA_W (32)
    ) u_imem (
        .clock (clock),
        .we    (w_mem_we),
        .waddr (imem_addr),
        .wdata (imem_wdata),
        .raddr (r_pc[PC_SIZE-1:2]),
        .rdata (w_fetch_word)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_LOAD;
            r_pc      <= '0;
            r_pc_out  <= '0;
            r_instr   <= NOP_INSTR;
            r_halted  <= 1'b0;
            r_loading <= 1'b1;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_loading <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        r_pc     <= w_redirect_pc;
                        r_pc_out <= r_pc;
                        r_instr  <= NOP_INSTR;
                    end else if (!stall) begin
                        r_instr  <= w_fetch_word;
                        r_pc_out <= r_pc;
                        // ECALL still reaches ID, but the PC parks on it.
                        if (w_fetch_word == c_ecall_instr) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_next;
                        end
                    end
                end
                ST_HALT: begin
                    if (branch_taken) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                        r_pc     <= w_redirect_pc;
                        r_pc_out <= r_pc;
                        r_instr  <= NOP_INSTR;
                    end else if (!stall) begin
                        r_instr <= NOP_INSTR;
                    end
                end
                default: begin
                    r_state   <= ST_LOAD;
                    r_loading <= 1'b1;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign PC_out      = r_pc_out;
    assign instruction = r_instr;
    assign halted      = r_halted;
    assign loading     = r_loading;

endmodule
`default_nettype wire
